// File: rtl/calc_pkg.sv
// Shared sizing for the dot-product pipeline: vector geometry and the
// bit width carried at each level of the adder tree.
package calc_pkg;

    localparam int N_ELEM = 16;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 20;

    // Each tree level widens by one bit so a pairwise sum can never carry out.
    localparam int PROD_W = 2 * DATA_W;   // 16
    localparam int SUM1_W = PROD_W + 1;   // 17
    localparam int SUM2_W = PROD_W + 2;   // 18
    localparam int SUM3_W = PROD_W + 3;   // 19
    localparam int SUM4_W = PROD_W + 4;   // 20

endpackage : calc_pkg

// File: rtl/calc_mul_pe.sv
// One lane of the dot product: unsigned DATA_W x DATA_W multiply with a
// registered, full-width product.
module calc_mul_pe
    import calc_pkg::*;
#(
    parameter int DATA_W = calc_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    // Product register; operands are zero-extended so the multiply is unsigned and exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= {(2*DATA_W){1'b0}};
        end else begin
            prod <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        end
    end

endmodule : calc_mul_pe

// File: rtl/calculation.sv
// Fully pipelined unsigned dot product of two packed N_ELEM-element vectors.
// Stage 1 registers the lane products, stages 2-5 form a binary adder tree
// that grows one bit per level, so the result is exact. The tree is built for
// N_ELEM = 16 (four adder levels). One new A/B pair is accepted every cycle.
module calculation
    import calc_pkg::*;
#(
    parameter int N_ELEM = calc_pkg::N_ELEM,
    parameter int DATA_W = calc_pkg::DATA_W,
    parameter int OUT_W  = calc_pkg::OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ELEM*DATA_W-1:0]   A,
    input  logic [N_ELEM*DATA_W-1:0]   B,
    output logic [OUT_W-1:0]           reg_out_O
);

    localparam int P_W  = 2 * DATA_W;
    localparam int S1_W = P_W + 1;
    localparam int S2_W = P_W + 2;
    localparam int S3_W = P_W + 3;
    localparam int S4_W = P_W + 4;

    logic [P_W-1:0]  prod [N_ELEM];
    logic [S1_W-1:0] sum1 [N_ELEM/2];
    logic [S2_W-1:0] sum2 [N_ELEM/4];
    logic [S3_W-1:0] sum3 [N_ELEM/8];

    // Stage 1: one multiplier lane per element; inputs feed the multipliers directly.
    for (genvar i = 0; i < N_ELEM; i++) begin : g_mul
        calc_mul_pe #(
            .DATA_W (DATA_W)
        ) u_pe (
            .clk  (clk),
            .rst  (rst),
            .a    (A[i*DATA_W +: DATA_W]),
            .b    (B[i*DATA_W +: DATA_W]),
            .prod (prod[i])
        );
    end

    // Stage 2: pairwise sums of products.
    for (genvar j = 0; j < N_ELEM/2; j++) begin : g_lvl1
        // Level-1 adder register.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum1[j] <= {S1_W{1'b0}};
            end else begin
                sum1[j] <= {1'b0, prod[2*j]} + {1'b0, prod[2*j+1]};
            end
        end
    end

    // Stage 3: pairwise sums of level-1 results.
    for (genvar j = 0; j < N_ELEM/4; j++) begin : g_lvl2
        // Level-2 adder register.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum2[j] <= {S2_W{1'b0}};
            end else begin
                sum2[j] <= {1'b0, sum1[2*j]} + {1'b0, sum1[2*j+1]};
            end
        end
    end

    // Stage 4: pairwise sums of level-2 results.
    for (genvar j = 0; j < N_ELEM/8; j++) begin : g_lvl3
        // Level-3 adder register.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum3[j] <= {S3_W{1'b0}};
            end else begin
                sum3[j] <= {1'b0, sum2[2*j]} + {1'b0, sum2[2*j+1]};
            end
        end
    end

    // Stage 5: final sum straight into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_out_O <= {OUT_W{1'b0}};
        end else begin
            reg_out_O <= OUT_W'({1'b0, sum3[0]} + {1'b0, sum3[1]});
        end
    end

    // Width of the final level, kept for readers checking OUT_W against the tree.
    localparam int TREE_OUT_W = S4_W;

endmodule : calculation

// File: tb/tb_calculation.sv
// Self-checking bench for the dot-product pipeline: reset behaviour, a table
// of directed vectors with exact latency checks, a full-rate random stream,
// and a reset pulse in the middle of a stream.
module tb_calculation;

    localparam int N_ELEM = 16;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 20;
    localparam int VW     = N_ELEM * DATA_W;

    typedef struct {
        string           name;
        logic [VW-1:0]   a;
        logic [VW-1:0]   b;
        logic [OUT_W-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [VW-1:0]    a_in = '0;
    logic [VW-1:0]    b_in = '0;
    logic [OUT_W-1:0] dut_out;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs [7];

    logic [VW-1:0]    rs_a [100];
    logic [VW-1:0]    rs_b [100];
    logic [OUT_W-1:0] rs_e [100];

    calculation #(
        .N_ELEM (N_ELEM),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a_in),
        .B         (b_in),
        .reg_out_O (dut_out)
    );

    always #5 clk = ~clk;

    // Reference dot product, computed element by element.
    function automatic logic [OUT_W-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [OUT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            acc = acc + OUT_W'(a[i*DATA_W +: DATA_W]) * OUT_W'(b[i*DATA_W +: DATA_W]);
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 20'h%05h want 20'h%05h", name, got, want);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [VW-1:0]    va;
        logic [VW-1:0]    vb;
        logic [OUT_W-1:0] prev_exp;

        // Directed table with hand-computed results.
        vecs[0] = '{"all_ff",  {VW{1'b1}}, {VW{1'b1}}, 20'hFE010};
        vecs[1] = '{"zeros",   {VW{1'b0}}, {VW{1'b0}}, 20'h00000};
        va = '0;
        vb = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            va[i*DATA_W +: DATA_W] = 8'(i + 1);
            vb[i*DATA_W +: DATA_W] = 8'h01;
        end
        vecs[2] = '{"ramp", va, vb, 20'h00088};
        va = '0;
        vb = '0;
        va[127:120] = 8'hFF;
        vb[127:120] = 8'h02;
        vecs[3] = '{"lane15", va, vb, 20'h001FE};
        va = '0;
        vb = '0;
        va[7:0] = 8'hFF;
        vb[7:0] = 8'h02;
        vecs[4] = '{"lane0", va, vb, 20'h001FE};
        for (int i = 0; i < N_ELEM; i++) begin
            va[i*DATA_W +: DATA_W] = 8'(i);
            vb[i*DATA_W +: DATA_W] = 8'(16 - i);
        end
        vecs[5] = '{"i_times_16mi", va, vb, 20'h002A8};
        for (int i = 0; i < N_ELEM; i++) begin
            va[i*DATA_W +: DATA_W] = 8'h80;
            vb[i*DATA_W +: DATA_W] = 8'h02;
        end
        vecs[6] = '{"half_by_two", va, vb, 20'h01000};

        // Reset held with maximal inputs: output must stay zero.
        rst  = 1'b1;
        a_in = {VW{1'b1}};
        b_in = {VW{1'b1}};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold", dut_out, 20'h00000);
        end

        // Release: zero for four edges, full-scale result on the fifth, then held.
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check(e < 5 ? "rst_release_zero" : "rst_release_max", dut_out, e < 5 ? 20'h00000 : 20'hFE010);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("max_held", dut_out, 20'hFE010);
        end

        // Flush with reset, then walk the directed table with exact latency.
        rst = 1'b1;
        tick();
        check("rst_flush", dut_out, 20'h00000);
        rst = 1'b0;
        prev_exp = 20'h00000;
        for (int v = 0; v < 7; v++) begin
            a_in = vecs[v].a;
            b_in = vecs[v].b;
            for (int e = 1; e <= 5; e++) begin
                tick();
                if (e == 4) check({vecs[v].name, "_early"}, dut_out, prev_exp);
                if (e == 5) check(vecs[v].name, dut_out, vecs[v].exp);
            end
            prev_exp = vecs[v].exp;
        end

        // Full-rate random stream: each output matches inputs from five edges earlier.
        for (int k = 0; k < 100; k++) begin
            rs_a[k] = rand_vec();
            rs_b[k] = rand_vec();
            rs_e[k] = dot(rs_a[k], rs_b[k]);
        end
        for (int c = 0; c < 104; c++) begin
            a_in = (c < 100) ? rs_a[c] : '0;
            b_in = (c < 100) ? rs_b[c] : '0;
            tick();
            if (c >= 4) check("stream", dut_out, rs_e[c-4]);
        end

        // Stream interrupted by a one-cycle reset: in-flight work is discarded.
        for (int c = 0; c < 10; c++) begin
            a_in = rs_a[c];
            b_in = rs_b[c];
            tick();
            if (c >= 4) check("pre_reset_stream", dut_out, rs_e[c-4]);
        end
        rst  = 1'b1;
        a_in = rs_a[10];
        b_in = rs_b[10];
        tick();
        check("mid_reset_edge", dut_out, 20'h00000);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            a_in = (c < 8) ? rs_a[20 + c] : '0;
            b_in = (c < 8) ? rs_b[20 + c] : '0;
            tick();
            if (c < 4) begin
                check("post_reset_zero", dut_out, 20'h00000);
            end else begin
                check("post_reset_resume", dut_out, rs_e[20 + c - 4]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_calculation
